vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Test-pattern pixel source that sits directly upstream of the `vga` timing stage. It drives that block's `data_i` and tracks the raster position by counting the pixels the timing stage consumes through its `ready_o` strobe. It offers four selectable patterns, including an animated bouncing box, so the display path can be brought up without a framebuffer.

## Interface
- `pixel_bits_p`, 8: bits per colour channel.
- `width_p`, 640: active pixels per line.
- `height_p`, 480: active lines per frame.
- `box_p`, 32: bouncing-box edge length in pixels. Must be less than both `width_p` and `height_p`.
- `clk_i`: input, 1 bit. Single clock, same clock as `vga`.
- `reset_i`: input, 1 bit. Synchronous, active-high reset.
- `ready_i`: input, 1 bit. Connect to `vga.ready_o`. High means the current pixel is consumed this cycle.
- `vsync_i`: input, 1 bit. Connect to `vga.vsync_o`. Used for position resynchronisation.
- `mode_i`: input, 2 bits. Pattern select. Sampled only at frame boundaries.
- `data_o`: output, `[2:0][pixel_bits_p-1:0]`. Pixel at the current position. `[2]` is red, `[1]` is green, `[0]` is blue. Connect to `vga.data_i`.
- `frame_o`: output, 1 bit. One-cycle pulse after each completed frame.

## Operation
- State registers:
  - `x_r`: range 0..`width_p`-1.
  - `y_r`: range 0..`height_p`-1.
  - `mode_r`: 2 bits.
  - `frame_cnt_r`: `pixel_bits_p` bits, wraps.
  - `box_x_r`, `box_y_r`: box position.
  - `dx_r`, `dy_r`: box direction. 0 means +1, 1 means −1.
- Position advance on each cycle with `ready_i`=1:
  - `x_r` increments by 1.
  - At `width_p`-1, `x_r` wraps to 0 and `y_r` increments.
  - At `y_r`=`height_p`-1 and `x_r`=`width_p`-1, both wrap to 0. This is the last-pixel event.
- Last-pixel event, applied in the same clock edge as the wrap:
  - `mode_r` ← `mode_i`.
  - `frame_cnt_r` increments by 1.
  - Box updates (see below).
  - `frame_o` pulses on the next cycle.
- Resync:
  - While `vsync_i`=1, `x_r` and `y_r` are forced to 0.
  - Resync takes priority over `ready_i`.
  - Resync does not trigger a frame update.
  - If `vsync_i`=1 and a last-pixel event occur in the same cycle, the frame update still happens and position ends at 0,0.
- Box update:
  - `box_x_r` ← `box_x_r` ± 1 according to `dx_r`.
  - If the new value equals 0 or `width_p`-`box_p`, `dx_r` flips.
  - Y axis behaves the same way against `height_p`-`box_p`.
- `data_o` is combinational from registered state only. There is no path from `ready_i` or `mode_i` to `data_o`. Full scale means all ones; zero means all zeros.
  - Mode 0, colour bars: 8 bars, bar index = `x_r`·8/`width_p` (integer). Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is full scale or zero.
  - Mode 1, checkerboard: white when `x_r`[5] XOR `y_r`[5] is 0, otherwise black.
  - Mode 2, ramps: red = `x_r` low `pixel_bits_p` bits, green = `y_r` low `pixel_bits_p` bits, blue = `frame_cnt_r`.
  - Mode 3, bouncing box: white if `box_x_r` ≤ `x_r` < `box_x_r`+`box_p` and `box_y_r` ≤ `y_r` < `box_y_r`+`box_p`; otherwise blue background (red=0, green=0, blue full scale).
- Arithmetic widths:
  - Counters are sized with `$clog2`.
  - Bar index uses a constant compare chain on `x_r`, not a divider.

## Timing
- Reset values:
  - `x_r`, `y_r`, `mode_r`, `frame_cnt_r`, `box_x_r`, `box_y_r`, `dx_r`, `dy_r` are all 0.
  - `frame_o` = 0.
  - `data_o` = mode 0 at x=0, which is white (all channels full scale).
- Reset applied mid-frame returns every register to its reset value on the next edge. It overrides `ready_i` and `vsync_i`.
- Latency and handshake:
  - `data_o` is valid in the same cycle that `ready_i` samples it.
  - Position changes at the edge that ends a `ready_i`=1 cycle.
  - `vga` registers `data_i` one cycle later; no extra alignment is required here.
- `ready_i` may be 1 for any run length, including every cycle. Consecutive pixels must then come out back-to-back with no bubbles.
- A `mode_i` change mid-frame takes effect only for the first pixel of the next frame.

## Test plan
- Reset with `ready_i`=0 → `data_o` = {FF,FF,FF}, `frame_o`=0. Hold 10 cycles: `data_o` unchanged, `x_r`=0.
- Mode 0, pulse `ready_i` 80 times → `data_o` switches from white to yellow {FF,FF,00} exactly after the 80th pulse. After 560 pulses total, `data_o` is black.
- Mode 2, drive 640×480 `ready_i` pulses → after the last pulse: x=0, y=0, `frame_o`=1 for exactly one cycle, blue channel = 01.
- Set `mode_i`=3 mid-frame → patterns stay as mode 0 until the frame ends; the next frame shows a box at (1,1). After 608 frames, `box_x_r`=608 and `dx_r`=1; after frame 609, `box_x_r`=607.
- `vsync_i`=1 at x=100, y=5 → position becomes 0,0; `frame_cnt_r` and box unchanged; `frame_o` stays 0.
- Assert `reset_i` at x=300 with `ready_i`=1 → next cycle all state is zero and `data_o` = {FF,FF,FF}.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// Test-pattern source for the vga timing stage: colour bars, checkerboard, ramps, bouncing box.
// data_o is combinational from registered raster state; the position advances on each ready_i strobe and holds otherwise.
module vga_pattern_gen #(
  parameter int pixel_bits_p = 8,
  parameter int width_p      = 640,
  parameter int height_p     = 480,
  parameter int box_p        = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         ready_i,
  input  logic                         vsync_i,
  input  logic [1:0]                   mode_i,
  output logic [2:0][pixel_bits_p-1:0] data_o,
  output logic                         frame_o
);

  localparam int xw_lp = $clog2(width_p);
  localparam int yw_lp = $clog2(height_p);

  logic [xw_lp-1:0]        x_r, box_x_r, box_x_n;
  logic [yw_lp-1:0]        y_r, box_y_r, box_y_n;
  logic [1:0]              mode_r;
  logic [pixel_bits_p-1:0] frame_cnt_r;
  logic                    dx_r, dy_r;
  logic                    x_last, y_last, last_pix;

  assign x_last   = (x_r == xw_lp'(width_p - 1));
  assign y_last   = (y_r == yw_lp'(height_p - 1));
  assign last_pix = ready_i & x_last & y_last;

  assign box_x_n = dx_r ? box_x_r - xw_lp'(1) : box_x_r + xw_lp'(1);
  assign box_y_n = dy_r ? box_y_r - yw_lp'(1) : box_y_r + yw_lp'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_r         <= '0;
      y_r         <= '0;
      mode_r      <= '0;
      frame_cnt_r <= '0;
      box_x_r     <= '0;
      box_y_r     <= '0;
      dx_r        <= 1'b0;
      dy_r        <= 1'b0;
      frame_o     <= 1'b0;
    end else begin
      frame_o <= last_pix;
      // vsync only realigns the raster; a coincident last pixel still closes the frame below
      if (vsync_i) begin
        x_r <= '0;
        y_r <= '0;
      end else if (ready_i) begin
        if (x_last) begin
          x_r <= '0;
          y_r <= y_last ? '0 : y_r + yw_lp'(1);
        end else begin
          x_r <= x_r + xw_lp'(1);
        end
      end
      if (last_pix) begin
        mode_r      <= mode_i;
        frame_cnt_r <= frame_cnt_r + pixel_bits_p'(1);
        box_x_r     <= box_x_n;
        box_y_r     <= box_y_n;
        if (box_x_n == '0 || box_x_n == xw_lp'(width_p - box_p)) dx_r <= ~dx_r;
        if (box_y_n == '0 || box_y_n == yw_lp'(height_p - box_p)) dy_r <= ~dy_r;
      end
    end
  end

  logic [2:0] bar;
  logic       check_white, in_box;

  always_comb begin
    bar = 3'd0;
    // bar k starts at ceil(k*width/8), i.e. floor(x*8/width) without a divider
    for (int k = 1; k < 8; k++) begin
      if (int'(x_r) >= (k * width_p + 7) / 8) bar = 3'(k);
    end
    check_white = (((int'(x_r) >> 5) ^ (int'(y_r) >> 5)) & 1) == 0;
    in_box = (int'(x_r) >= int'(box_x_r)) && (int'(x_r) < int'(box_x_r) + box_p) &&
             (int'(y_r) >= int'(box_y_r)) && (int'(y_r) < int'(box_y_r) + box_p);

    data_o = '0;
    case (mode_r)
      2'd0: begin
        // bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0]
        data_o[2] = {pixel_bits_p{~bar[1]}};
        data_o[1] = {pixel_bits_p{~bar[2]}};
        data_o[0] = {pixel_bits_p{~bar[0]}};
      end
      2'd1: begin
        data_o[2] = {pixel_bits_p{check_white}};
        data_o[1] = {pixel_bits_p{check_white}};
        data_o[0] = {pixel_bits_p{check_white}};
      end
      2'd2: begin
        data_o[2] = pixel_bits_p'(x_r);
        data_o[1] = pixel_bits_p'(y_r);
        data_o[0] = frame_cnt_r;
      end
      default: begin
        data_o[2] = {pixel_bits_p{in_box}};
        data_o[1] = {pixel_bits_p{in_box}};
        data_o[0] = '1;
      end
    endcase
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized scoreboard bench for vga_pattern_gen using a small raster so many frames and box bounces fit.
module tb_vga_pattern_gen;

  localparam int W  = 44;
  localparam int H  = 14;
  localparam int B  = 6;
  localparam int PB = 5;
  localparam int NCYC = 48000;

  typedef logic [2:0][PB-1:0] pix_t;
  typedef struct {
    pix_t data;
    logic frame;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_i, ready_i, vsync_i;
  logic [1:0] mode_i;
  pix_t       data_o;
  logic       frame_o;

  vga_pattern_gen #(
    .pixel_bits_p(PB), .width_p(W), .height_p(H), .box_p(B)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .ready_i(ready_i), .vsync_i(vsync_i),
    .mode_i(mode_i), .data_o(data_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Triangle wave: box position after n frames bouncing over 0..L
  function automatic int tri_pos(int n, int L);
    int m;
    m = n % (2 * L);
    return (m <= L) ? m : 2 * L - m;
  endfunction

  function automatic pix_t ref_pix(int mode, int x, int y, int frames);
    pix_t p;
    logic [PB-1:0] full, zero;
    logic [2:0] rgb;
    int bx, by;
    full = '1;
    zero = '0;
    p = '0;
    case (mode)
      0: begin
        case (x * 8 / W)
          0: rgb = 3'b111;  // white
          1: rgb = 3'b110;  // yellow
          2: rgb = 3'b011;  // cyan
          3: rgb = 3'b010;  // green
          4: rgb = 3'b101;  // magenta
          5: rgb = 3'b100;  // red
          6: rgb = 3'b001;  // blue
          default: rgb = 3'b000;
        endcase
        p[2] = rgb[2] ? full : zero;
        p[1] = rgb[1] ? full : zero;
        p[0] = rgb[0] ? full : zero;
      end
      1: begin
        if ((((x / 32) + (y / 32)) % 2) == 0) p = {full, full, full};
        else p = {zero, zero, zero};
      end
      2: begin
        p[2] = PB'(x % (1 << PB));
        p[1] = PB'(y % (1 << PB));
        p[0] = PB'(frames % (1 << PB));
      end
      default: begin
        bx = tri_pos(frames, W - B);
        by = tri_pos(frames, H - B);
        if (x >= bx && x < bx + B && y >= by && y < by + B) p = {full, full, full};
        else p = {zero, zero, full};
      end
    endcase
    return p;
  endfunction

  // Monitor: the DUT presents a pixel every cycle; compare it away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (data_o !== e.data || frame_o !== e.frame) begin
          fails++;
          $display("FAIL pixel cyc=%0d got data=%h frame=%b expected data=%h frame=%b",
                   e.cyc, data_o, frame_o, e.data, e.frame);
        end
      end
    end
  end

  // Reference model state: linear pixel index, frames since reset, latched mode, pending pulse.
  int pos, frames, cur_mode;
  bit pulse;

  initial begin
    exp_t e;
    bit   last;
    reset_i = 1'b1;
    ready_i = 1'b0;
    vsync_i = 1'b0;
    mode_i  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    pos = 0; frames = 0; cur_mode = 0; pulse = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset_i = (cyc < 10) || (cyc >= 3000 && cyc < 3002);
      if (cyc < 10) ready_i = 1'b0;
      else if (reset_i) ready_i = 1'b1;
      else ready_i = ($urandom_range(0, 9) != 0);
      vsync_i = ($urandom_range(0, 1999) == 0) ||
                (pos == W * H - 1 && $urandom_range(0, 3) == 0);
      if (cyc >= 10 && $urandom_range(0, 299) == 0) mode_i = 2'($urandom_range(0, 3));

      e.data  = ref_pix(cur_mode, pos % W, pos / W, frames);
      e.frame = pulse;
      e.cyc   = cyc;
      sb.push_back(e);

      if (reset_i) begin
        pos = 0; frames = 0; cur_mode = 0; pulse = 1'b0;
      end else begin
        last  = ready_i && (pos == W * H - 1);
        pulse = last;
        if (last) begin
          frames++;
          cur_mode = int'(mode_i);
        end
        if (vsync_i || last) pos = 0;
        else if (ready_i) pos++;
      end

      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain leftover=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
